// File: rtl/sdram_port_rr_arb_if.sv
// Bundle of the four client request/acknowledge lanes and the single
// toggle-handshake SDRAM port that the round-robin arbiter sits between.
interface sdram_port_rr_arb_if #(
   parameter int AW = 23,
   parameter int DW = 16
);
   // Client side: level request in, one-cycle acknowledge out
   logic [3:0]      c_req;
   logic [3:0]      c_we;
   logic [4*AW-1:0] c_addr;
   logic [7:0]      c_ds;
   logic [4*DW-1:0] c_d;
   logic [3:0]      c_ack;
   logic [DW-1:0]   c_q;

   // SDRAM port side: toggle request out, toggle acknowledge in
   logic            mem_req;
   logic            mem_ack;
   logic            mem_we;
   logic [AW-1:0]   mem_a;
   logic [1:0]      mem_ds;
   logic [DW-1:0]   mem_d;
   logic [DW-1:0]   mem_q;

   // Arbiter view
   modport slave (
      input  c_req, c_we, c_addr, c_ds, c_d, mem_ack, mem_q,
      output c_ack, c_q, mem_req, mem_we, mem_a, mem_ds, mem_d
   );

   // Environment view (clients plus SDRAM controller)
   modport master (
      output c_req, c_we, c_addr, c_ds, c_d, mem_ack, mem_q,
      input  c_ack, c_q, mem_req, mem_we, mem_a, mem_ds, mem_d
   );
endinterface

// File: rtl/sdram_port_rr_arb.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM port among four
// level-request clients. One transaction in flight at a time; read data is
// latched for the acknowledge cycle and a stuck controller raises a sticky flag.
module sdram_port_rr_arb #(
   parameter int AW      = 23,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   sdram_port_rr_arb_if.slave bus,
   output logic               busy,
   output logic [1:0]         grant_id,
   output logic               timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   state_t        state_q,   state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q,  mem_we_d;
   logic [AW-1:0] mem_a_q,   mem_a_d;
   logic [1:0]    mem_ds_q,  mem_ds_d;
   logic [DW-1:0] mem_d_q,   mem_d_d;
   logic [3:0]    c_ack_q,   c_ack_d;
   logic [DW-1:0] c_q_q,     c_q_d;
   logic [1:0]    grant_q,   grant_d;
   logic          err_q,     err_d;
   logic [7:0]    cnt_q,     cnt_d;

   logic          win_vld;
   logic [1:0]    win_id;
   logic [1:0]    scan;
   logic [31:0]   win_sel;

   // Pick the first requester after the previous owner, wrapping modulo 4
   always_comb begin
      win_vld = 1'b0;
      win_id  = grant_q;
      scan    = grant_q;
      for (int k = 1; k <= 4; k++) begin
         scan = grant_q + 2'(k);
         if (!win_vld && bus.c_req[scan]) begin
            win_vld = 1'b1;
            win_id  = scan;
         end
      end
   end

   assign win_sel = 32'(win_id);

   // Next-state and datapath decisions for the IDLE -> WAIT -> DONE cycle
   always_comb begin
      state_d   = state_q;
      mem_req_d = mem_req_q;
      mem_we_d  = mem_we_q;
      mem_a_d   = mem_a_q;
      mem_ds_d  = mem_ds_q;
      mem_d_d   = mem_d_q;
      c_ack_d   = 4'b0000;
      c_q_d     = c_q_q;
      grant_d   = grant_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               mem_we_d  = bus.c_we[win_id];
               mem_a_d   = bus.c_addr[win_sel*AW +: AW];
               mem_ds_d  = bus.c_ds[win_sel*2 +: 2];
               mem_d_d   = bus.c_d[win_sel*DW +: DW];
               grant_d   = win_id;
               mem_req_d = ~mem_req_q;
               cnt_d     = 8'd0;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.mem_ack == mem_req_q) begin
               c_q_d   = bus.mem_q;
               c_ack_d = 4'b0001 << grant_q;
               cnt_d   = 8'd0;
               state_d = S_DONE;
            end else begin
               // Never abandon: a late toggle would desynchronise the handshake
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               if (cnt_d >= TO_LIM) err_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset re-aligns mem_req to mem_ack so no request is issued
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mem_req_q <= bus.mem_ack;
         mem_we_q  <= 1'b0;
         mem_a_q   <= '0;
         mem_ds_q  <= 2'b00;
         mem_d_q   <= '0;
         c_ack_q   <= 4'b0000;
         c_q_q     <= '0;
         grant_q   <= 2'd3;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         mem_a_q   <= mem_a_d;
         mem_ds_q  <= mem_ds_d;
         mem_d_q   <= mem_d_d;
         c_ack_q   <= c_ack_d;
         c_q_q     <= c_q_d;
         grant_q   <= grant_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_a    = mem_a_q;
   assign bus.mem_ds   = mem_ds_q;
   assign bus.mem_d    = mem_d_q;
   assign bus.c_ack    = c_ack_q;
   assign bus.c_q      = c_q_q;
   assign busy         = (state_q != S_IDLE);
   assign grant_id     = grant_q;
   assign timeout_err  = err_q;

endmodule

// File: tb/tb_sdram_port_rr_arb.sv
// Bench for the SDRAM port round-robin arbiter: directed scenarios plus a
// randomized traffic phase checked against a transaction-level reference.
module tb_sdram_port_rr_arb;
   localparam int AW = 23;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   logic [1:0] grant_id;
   logic timeout_err;

   always #5 clk = ~clk;

   sdram_port_rr_arb_if #(.AW(AW), .DW(DW)) bus ();

   sdram_port_rr_arb #(.AW(AW), .DW(DW), .TIMEOUT(255)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   int total = 0;
   int bad   = 0;

   // SDRAM controller model state
   int         lat      = 2;
   bit         hold     = 1'b0;
   bit         ack_init = 1'b1;
   int         tog      = 0;
   logic       prev_req;
   bit         pend     = 1'b0;
   int         wcnt     = 0;
   logic [15:0] rdata;
   logic [15:0] mcur;
   logic [15:0] cmem [logic [22:0]];
   logic [15:0] refm [logic [22:0]];

   // Client request bookkeeping for the randomized phase
   logic [3:0]  reqset;
   bit          pwe [4];
   logic [22:0] pa  [4];
   logic [1:0]  pds [4];
   logic [15:0] pd  [4];
   logic [22:0] atbl [6] = '{23'h7FFFFF, 23'h000000, 23'h0000A0,
                             23'h400001, 23'h055555, 23'h2AAAAA};

   function automatic logic [15:0] dflt(input logic [22:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                         input logic [1:0] ds);
      logic [15:0] r;
      r = old;
      if (ds[1]) r[15:8] = d[15:8];
      if (ds[0]) r[7:0]  = d[7:0];
      return r;
   endfunction

   // Toggle-handshake controller: answers each new request after lat cycles
   always @(negedge clk) begin
      if (reset) begin
         bus.mem_ack = ack_init;
         bus.mem_q   = 16'h0000;
         pend        = 1'b0;
      end else begin
         if (bus.mem_req !== prev_req) tog++;
         if (pend) begin
            wcnt++;
            if (!hold && wcnt >= lat) begin
               bus.mem_q   = rdata;
               bus.mem_ack = bus.mem_req;
               pend        = 1'b0;
            end
         end else if (bus.mem_req !== bus.mem_ack) begin
            pend = 1'b1;
            wcnt = 0;
            mcur = cmem.exists(bus.mem_a) ? cmem[bus.mem_a] : dflt(bus.mem_a);
            if (bus.mem_we) begin
               cmem[bus.mem_a] = merge(mcur, bus.mem_d, bus.mem_ds);
               rdata = 16'($urandom);
            end else begin
               rdata = mcur;
            end
         end
      end
      prev_req = bus.mem_req;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_client(input int i, input bit req, input bit we, input logic [22:0] a,
                             input logic [1:0] ds, input logic [15:0] d);
      bus.c_req[i]            = req;
      bus.c_we[i]             = we;
      bus.c_addr[i*AW +: AW]  = a;
      bus.c_ds[i*2 +: 2]      = ds;
      bus.c_d[i*DW +: DW]     = d;
   endtask

   task automatic wait_ack(input string tag, input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.c_ack === 4'b0000 && n < bound);
      chk({tag, "_ack_seen"}, 64'(bus.c_ack !== 4'b0000), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [15:0] refv(input logic [22:0] a);
      return refm.exists(a) ? refm[a] : dflt(a);
   endfunction

   task automatic new_req(input int i);
      pwe[i] = 1'($urandom_range(1, 0));
      pa[i]  = atbl[$urandom_range(5, 0)];
      pds[i] = 2'($urandom);
      pd[i]  = 16'($urandom);
      reqset[i] = 1'b1;
      set_client(i, 1'b1, pwe[i], pa[i], pds[i], pd[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int t0;
      int ex;
      logic [3:0] seen;
      logic [3:0] e;

      reset      = 1'b1;
      bus.c_req  = '0;
      bus.c_we   = '0;
      bus.c_addr = '0;
      bus.c_ds   = '0;
      bus.c_d    = '0;
      reqset     = '0;

      // Step 1: reset with mem_ack=1, then quiet for 100 cycles
      ack_init = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      chk("rst_mem_req", bus.mem_req, 1);
      chk("rst_c_ack", bus.c_ack, 0);
      chk("rst_c_q", bus.c_q, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_a", bus.mem_a, 0);
      chk("rst_mem_ds", bus.mem_ds, 0);
      chk("rst_mem_d", bus.mem_d, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 3);
      chk("rst_err", timeout_err, 0);
      t0 = tog;
      repeat (100) @(negedge clk);
      chk("idle_no_toggle", tog - t0, 0);
      chk("idle_mem_req", bus.mem_req, 1);

      // Step 2: client 2 write, controller answers after 6 cycles
      t0  = tog;
      lat = 6;
      set_client(2, 1'b1, 1'b1, 23'h12345, 2'b11, 16'hBEEF);
      wait_ack("wr2", 50, n);
      chk("wr2_latency", n, 8);
      chk("wr2_c_ack", bus.c_ack, 4'b0100);
      chk("wr2_mem_a", bus.mem_a, 23'h12345);
      chk("wr2_mem_we", bus.mem_we, 1);
      chk("wr2_mem_d", bus.mem_d, 16'hBEEF);
      chk("wr2_mem_ds", bus.mem_ds, 2'b11);
      chk("wr2_grant", grant_id, 2);
      chk("wr2_busy", busy, 1);
      chk("wr2_toggles", tog - t0, 1);
      set_client(2, 1'b0, 1'b0, '0, 2'b00, '0);
      @(negedge clk);
      chk("wr2_ack_width", bus.c_ack, 0);
      chk("wr2_idle", busy, 0);

      // Step 3: all four requesting continuously, eight grants after reset
      ack_init = 1'b0;
      do_reset();
      lat = 2;
      for (int i = 0; i < 4; i++) set_client(i, 1'b1, 1'b0, 23'h100 + 23'(i), 2'b11, '0);
      for (int k = 0; k < 8; k++) begin
         wait_ack("rr", 40, n);
         e = 4'(1 << (k % 4));
         chk("rr_order", bus.c_ack, e);
         chk("rr_onehot", 64'($onehot(bus.c_ack)), 1);
         chk("rr_grant_id", grant_id, k % 4);
         if (k == 7) bus.c_req = '0;
      end
      @(negedge clk);
      chk("rr_ack_clear", bus.c_ack, 0);

      // Step 4: client 1 read of a known word; dropping req prevents re-grant
      cmem[23'h0BCDE] = 16'hA5A5;
      lat = 3;
      set_client(1, 1'b1, 1'b0, 23'h0BCDE, 2'b11, '0);
      wait_ack("rd1", 40, n);
      chk("rd1_c_ack", bus.c_ack, 4'b0010);
      chk("rd1_c_q", bus.c_q, 16'hA5A5);
      set_client(1, 1'b0, 1'b0, '0, 2'b00, '0);
      t0   = tog;
      seen = '0;
      repeat (20) begin
         @(negedge clk);
         seen |= bus.c_ack;
      end
      chk("rd1_no_regrant_ack", seen, 0);
      chk("rd1_no_regrant_tog", tog - t0, 0);

      // Step 5: controller stalls for 300 cycles
      hold = 1'b1;
      lat  = 1;
      set_client(0, 1'b1, 1'b1, 23'h000777, 2'b01, 16'h1234);
      repeat (255) @(negedge clk);
      chk("to_err_before", timeout_err, 0);
      chk("to_busy", busy, 1);
      @(negedge clk);
      chk("to_err_set", timeout_err, 1);
      repeat (44) @(negedge clk);
      hold = 1'b0;
      wait_ack("to_late", 20, n);
      chk("to_late_c_ack", bus.c_ack, 4'b0001);
      chk("to_err_sticky", timeout_err, 1);
      set_client(0, 1'b0, 1'b0, '0, 2'b00, '0);
      repeat (5) @(negedge clk);
      chk("to_err_still", timeout_err, 1);
      chk("to_idle", busy, 0);

      // Step 6: reset while waiting on the controller
      hold = 1'b1;
      set_client(2, 1'b1, 1'b0, 23'h000321, 2'b11, '0);
      repeat (5) @(negedge clk);
      chk("rw_in_wait", busy, 1);
      seen     = '0;
      ack_init = 1'b1;
      reset    = 1'b1;
      set_client(2, 1'b0, 1'b0, '0, 2'b00, '0);
      repeat (3) begin
         @(negedge clk);
         seen |= bus.c_ack;
      end
      reset = 1'b0;
      hold  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= bus.c_ack;
      end
      chk("rw_no_ack", seen, 0);
      chk("rw_req_eq_ack", 64'(bus.mem_req === bus.mem_ack), 1);
      chk("rw_mem_req", bus.mem_req, 1);
      chk("rw_err_cleared", timeout_err, 0);
      chk("rw_idle", busy, 0);
      t0  = tog;
      lat = 3;
      set_client(0, 1'b1, 1'b0, 23'h000321, 2'b11, '0);
      wait_ack("rw_next", 40, n);
      chk("rw_next_c_ack", bus.c_ack, 4'b0001);
      chk("rw_next_toggles", tog - t0, 1);
      set_client(0, 1'b0, 1'b0, '0, 2'b00, '0);
      @(negedge clk);

      // Step 7: randomized traffic against the transaction-level reference
      ack_init = 1'($urandom);
      do_reset();
      ex = 3;
      reqset = '0;
      for (int i = 0; i < 4; i++) if ($urandom_range(1, 0) == 1) new_req(i);
      if (reqset == 4'b0000) new_req(int'($urandom_range(3, 0)));
      lat = int'($urandom_range(6, 1));
      for (int t = 0; t < 60; t++) begin
         int w;
         wait_ack("rnd", 40, n);
         w = -1;
         for (int s = 1; s <= 4; s++) if (w < 0 && reqset[(ex + s) % 4]) w = (ex + s) % 4;
         e = 4'(1 << w);
         chk("rnd_grant", bus.c_ack, e);
         if (pwe[w]) refm[pa[w]] = merge(refv(pa[w]), pd[w], pds[w]);
         else chk("rnd_read_q", bus.c_q, refv(pa[w]));
         ex = w;
         if ($urandom_range(1, 0) == 1) begin
            new_req(w);
         end else begin
            reqset[w]    = 1'b0;
            bus.c_req[w] = 1'b0;
         end
         for (int i = 0; i < 4; i++)
            if (!reqset[i] && i != w && $urandom_range(2, 0) == 0) new_req(i);
         if (reqset == 4'b0000) new_req(int'($urandom_range(3, 0)));
         lat = int'($urandom_range(6, 1));
      end
      bus.c_req = '0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
